// File: rtl/pnr_pkg.sv
// ---------------------------------------------------------------------------
// pnr_pkg
// Shared encodings for the PNR trigger scheduler:
//   trig_mode_t    - edge selection applied to the Schmitt edge detector
//   sched_state_t  - state encoding of the scheduler FSM
// ---------------------------------------------------------------------------
package pnr_pkg;

    // Edge selection on the trig_mode input
    typedef enum logic [1:0] {
        TRIG_RISE = 2'b00,
        TRIG_FALL = 2'b01,
        TRIG_BOTH = 2'b10,
        TRIG_OFF  = 2'b11
    } trig_mode_t;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_DELAY   = 2'b01,
        ST_HOLDOFF = 2'b10
    } sched_state_t;

endpackage

// File: rtl/pnr_schmitt.sv
// ---------------------------------------------------------------------------
// pnr_schmitt
// Threshold comparator with hysteresis and edge detection for the trigger
// channel. A sample presented in cycle N produces edge_pulse in cycle N+2.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   sample     : signed trigger-channel sample
//   threshold  : signed trigger threshold
//   hyst       : unsigned hysteresis magnitude
//   mode       : edge selection (see pnr_pkg::trig_mode_t)
//   edge_pulse : one-cycle pulse for each selected edge
// ---------------------------------------------------------------------------
module pnr_schmitt
    import pnr_pkg::*;
#(
    parameter int DW = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] sample,
    input  logic signed [DW-1:0] threshold,
    input  logic        [DW-1:0] hyst,
    input  logic        [1:0]    mode,
    output logic                 edge_pulse
);

    // Two extra bits so threshold +/- hyst can never wrap before saturation
    localparam int EW = DW + 2;
    localparam logic signed [EW-1:0] MAX_V = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V = {3'b111, {(DW-1){1'b0}}};

    logic signed [EW-1:0] thr_ext;
    logic signed [EW-1:0] hyst_ext;
    logic signed [EW-1:0] sum_p;
    logic signed [EW-1:0] sum_m;
    logic signed [DW-1:0] thr_p_next;
    logic signed [DW-1:0] thr_m_next;

    logic signed [DW-1:0] thr_p;
    logic signed [DW-1:0] thr_m;
    logic                 st_valid;
    logic                 rise_st;
    logic                 fall_st;
    logic                 rise_prev;
    logic                 fall_prev;
    logic                 rise_ok;
    logic                 fall_ok;
    logic                 rise_new;
    logic                 fall_new;

    assign thr_ext  = {{2{threshold[DW-1]}}, threshold};
    assign hyst_ext = {2'b00, hyst};
    assign sum_p    = thr_ext + hyst_ext;
    assign sum_m    = thr_ext - hyst_ext;

    assign thr_p_next = (sum_p > MAX_V) ? MAX_V[DW-1:0] :
                        (sum_p < MIN_V) ? MIN_V[DW-1:0] : sum_p[DW-1:0];
    assign thr_m_next = (sum_m > MAX_V) ? MAX_V[DW-1:0] :
                        (sum_m < MIN_V) ? MIN_V[DW-1:0] : sum_m[DW-1:0];

    // An edge only counts once the state has been seen in its inactive
    // level after reset, so a condition already true at release is ignored.
    assign rise_new = rise_st & ~rise_prev & rise_ok;
    assign fall_new = fall_st & ~fall_prev & fall_ok;

    // Schmitt states, edge history and registered edge selection.
    // st_valid marks that the states hold a real evaluation rather than
    // their reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_p      <= '0;
            thr_m      <= '0;
            st_valid   <= 1'b0;
            rise_st    <= 1'b0;
            fall_st    <= 1'b0;
            rise_prev  <= 1'b0;
            fall_prev  <= 1'b0;
            rise_ok    <= 1'b0;
            fall_ok    <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            thr_p    <= thr_p_next;
            thr_m    <= thr_m_next;
            st_valid <= 1'b1;

            if (sample >= threshold) begin
                rise_st <= 1'b1;
            end else if (sample < thr_m) begin
                rise_st <= 1'b0;
            end

            if (sample <= threshold) begin
                fall_st <= 1'b1;
            end else if (sample > thr_p) begin
                fall_st <= 1'b0;
            end

            rise_prev <= rise_st;
            fall_prev <= fall_st;
            rise_ok   <= rise_ok | (st_valid & ~rise_st);
            fall_ok   <= fall_ok | (st_valid & ~fall_st);

            case (trig_mode_t'(mode))
                TRIG_RISE: edge_pulse <= rise_new;
                TRIG_FALL: edge_pulse <= fall_new;
                TRIG_BOTH: edge_pulse <= rise_new | fall_new;
                default:   edge_pulse <= 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/pnr_trig_sched.sv
// ---------------------------------------------------------------------------
// pnr_trig_sched
// Trigger scheduler: detects edges on the trigger channel, and for each
// accepted trigger captures the PNR channel a programmable number of cycles
// later, then holds off further triggers for a programmable clearance.
//
// Ports
//   ADC_CLK         : sole clock, rising edge
//   rst_i           : asynchronous active-high reset
//   trig_source_sig : signed trigger-channel sample
//   pnr_source_sig  : signed PNR-channel sample
//   trig_threshold  : signed trigger threshold
//   trig_hyst       : unsigned hysteresis magnitude
//   trig_mode       : 00 rising, 01 falling, 10 both, 11 disabled
//   trig_clearance  : holdoff cycles counted from acceptance
//   pnr_delay       : cycles from acceptance to PNR capture
//   arm_i           : triggers accepted only while high
//   trig_o          : one-cycle pulse per accepted trigger
//   busy_o          : high while the FSM is not idle
//   sample_o        : captured PNR sample
//   sample_valid_o  : one-cycle pulse qualifying sample_o
//   trig_cnt_o      : accepted-trigger count (wraps)
//   drop_cnt_o      : rejected-edge count (saturates)
// ---------------------------------------------------------------------------
module pnr_trig_sched
    import pnr_pkg::*;
#(
    parameter int DW = 14,
    parameter int CW = 32
) (
    input  logic                 ADC_CLK,
    input  logic                 rst_i,
    input  logic signed [DW-1:0] trig_source_sig,
    input  logic signed [DW-1:0] pnr_source_sig,
    input  logic signed [DW-1:0] trig_threshold,
    input  logic        [DW-1:0] trig_hyst,
    input  logic        [1:0]    trig_mode,
    input  logic        [CW-1:0] trig_clearance,
    input  logic        [CW-1:0] pnr_delay,
    input  logic                 arm_i,
    output logic                 trig_o,
    output logic                 busy_o,
    output logic signed [DW-1:0] sample_o,
    output logic                 sample_valid_o,
    output logic        [CW-1:0] trig_cnt_o,
    output logic        [CW-1:0] drop_cnt_o
);

    sched_state_t  state;
    logic          edge_pulse;
    logic [CW-1:0] dly_cnt;
    logic [CW-1:0] clr_cnt;
    logic [CW-1:0] dly_lat;
    logic [CW-1:0] clr_lat;
    logic [CW:0]   clr_next;
    logic          clr_done;
    logic          drop_edge;

    pnr_schmitt #(
        .DW(DW)
    ) u_schmitt (
        .clk        (ADC_CLK),
        .rst        (rst_i),
        .sample     (trig_source_sig),
        .threshold  (trig_threshold),
        .hyst       (trig_hyst),
        .mode       (trig_mode),
        .edge_pulse (edge_pulse)
    );

    // The clearance counter reads k in the k-th cycle after acceptance, so
    // comparing its next value makes busy_o last exactly trig_clearance
    // cycles (never shorter than delay+2, the capture path).
    assign clr_next  = {1'b0, clr_cnt} + (CW+1)'(1);
    assign clr_done  = (clr_next >= {1'b0, clr_lat});
    assign drop_edge = edge_pulse & ((state != ST_IDLE) | ~arm_i);

    // Scheduler FSM with registered outputs. Config is latched at acceptance
    // so later changes only affect the next trigger; arm_i only gates
    // acceptance and never aborts an in-flight capture.
    always_ff @(posedge ADC_CLK or posedge rst_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            trig_o         <= 1'b0;
            busy_o         <= 1'b0;
            sample_o       <= '0;
            sample_valid_o <= 1'b0;
            trig_cnt_o     <= '0;
            drop_cnt_o     <= '0;
            dly_cnt        <= '0;
            clr_cnt        <= '0;
            dly_lat        <= '0;
            clr_lat        <= '0;
        end else begin
            trig_o         <= 1'b0;
            sample_valid_o <= 1'b0;

            if (drop_edge && (drop_cnt_o != '1)) begin
                drop_cnt_o <= drop_cnt_o + CW'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (edge_pulse && arm_i) begin
                        trig_o     <= 1'b1;
                        busy_o     <= 1'b1;
                        trig_cnt_o <= trig_cnt_o + CW'(1);
                        dly_lat    <= pnr_delay;
                        clr_lat    <= trig_clearance;
                        dly_cnt    <= '0;
                        clr_cnt    <= '0;
                        state      <= ST_DELAY;
                    end
                end

                ST_DELAY: begin
                    if (clr_cnt != '1) begin
                        clr_cnt <= clr_cnt + CW'(1);
                    end
                    if (dly_cnt == dly_lat) begin
                        sample_o       <= pnr_source_sig;
                        sample_valid_o <= 1'b1;
                        state          <= ST_HOLDOFF;
                    end else begin
                        dly_cnt <= dly_cnt + CW'(1);
                    end
                end

                ST_HOLDOFF: begin
                    if (clr_done) begin
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (clr_cnt != '1) begin
                        clr_cnt <= clr_cnt + CW'(1);
                    end
                end

                default: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
